johnson_phase_decoder: RTL
==========================

# johnson_phase_decoder

Downstream consumer of the Johnson counter (2·WIDTH-state twisted-ring code). Converts each sampled Johnson code into a binary phase index and a one-hot phase strobe. Checks that every new code is the legal successor of the previous one. Runs a lock state machine and optionally counts full ring revolutions, so the rest of the design sees a verified phase rather than raw ring bits.

## Interface
- WIDTH, 4, Johnson code width; ring has 2·WIDTH states
- LOCK_CNT, 3, consecutive good steps required to enter LOCKED (≥1)
- CNT_W, 8, width of revolution counter
- PW (localparam), $clog2(2·WIDTH), phase index width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  sample strobe; jc_in is a new code this cycle
- jc_in  in  WIDTH  Johnson code from upstream counter
- phase  out  PW  decoded phase index of last sample
- onehot  out  2·WIDTH  bit[phase] set when valid, else 0
- valid  out  1  last sample was a legal code
- illegal  out  1  one-cycle pulse: sampled code is not a Johnson code
- step_err  out  1  one-cycle pulse: legal code but not successor of previous legal code
- locked  out  1  lock state machine is in LOCKED
- wrap_cnt  out  CNT_W  saturating count of revolutions while locked

## Operation
- Ring order (WIDTH=4): 0000→0001→0011→0111→1111→1110→1100→1000→0000; next = {jc[WIDTH-2:0], ~jc[WIDTH-1]}.
- Decode, combinational on jc_in, with p = popcount(jc_in):
  - jc_in==0 → phase 0
  - jc_in[0]==1 → phase p
  - otherwise → phase 2·WIDTH−p
- Legal iff re-encoding the decoded phase reproduces jc_in exactly. Re-encoding:
  - phase k≤WIDTH → k ones at LSB
  - phase k>WIDTH → 2·WIDTH−k ones at MSB
- Internal state: prev_phase (PW bits), prev_ok flag, good-step counter, FSM.
- Sample with en=1 and legal code:
  - if prev_ok and phase==(prev_phase+1) mod 2·WIDTH → good step
  - else if prev_ok → step_err pulse
  - prev_phase←phase, prev_ok←1
- Sample with en=1 and illegal code: illegal pulse, valid←0, onehot←0, prev_ok←0, phase holds last value.
- en=0: all registers hold; pulses deassert.
- FSM:
  - UNLOCK: first good step → TRACK with count=1 (LOCK_CNT=1 → LOCKED directly).
  - TRACK: good step increments count; count reaching LOCK_CNT → LOCKED. Any illegal/step_err → UNLOCK, count=0. Sample with prev_ok=0 (first after reset/illegal) is neither good nor error, and keeps state.
  - LOCKED: illegal or step_err → UNLOCK, count=0. locked deasserts the same cycle the pulse asserts.
- wrap_cnt: increments on a good step from phase 2·WIDTH−1 to phase 0, only while in LOCKED before that edge; saturates at 2^CNT_W−1.

## Timing
- All outputs registered; sample at edge N appears after edge N (1-cycle latency).
- illegal and step_err are high for exactly one cycle per offending sample.
- Reset values: phase=0, onehot=0, valid=0, illegal=0, step_err=0, locked=0, wrap_cnt=0, prev_ok=0, FSM=UNLOCK.
- rst dominates en on the same edge; reset mid-lock drops locked and clears wrap_cnt next cycle.
- Lock timing: with clean samples on consecutive edges from reset release, the first sample is reference-only. locked rises after the edge of sample LOCK_CNT+1.

## Configuration
- JOHNSON_DEC_WRAPCNT_EN defined: revolution counter and saturation logic present as above.
- Undefined: no counter flops; wrap_cnt tied to 0. All other behaviour is identical.

## Test plan
- Reset, then 0000,0001,0011,0111 on consecutive en cycles, WIDTH=4, LOCK_CNT=3 → phase 0,1,2,3; onehot 00000001…00001000; locked=1 after the 4th sample.
- Locked, then feed 1010 → illegal pulse 1 cycle, valid=0, onehot=0, locked=0. Next sample 1100 → no step_err, prev_ok restored.
- Locked at 0011, then feed 1111 (skip) → step_err pulse, locked=0, phase=4. Next three clean successors → locked=1 again.
- Two clean revolutions after lock (define set) → wrap_cnt=2. With CNT_W=2 and 5 revolutions → saturates at 3. Define unset → wrap_cnt stays 0.
- en=0 for 5 cycles mid-sequence with jc_in changing → outputs frozen. Resuming with the correct successor → no error.
- Assert rst while locked with wrap_cnt=3, with en=1 on the same edge → all outputs zero next cycle, FSM=UNLOCK.

Source files
------------

// File: rtl/johnson_phase_decoder.sv
// Johnson ring decoder: phase index, one-hot strobe, successor check, lock FSM.
// Optional revolution counter enabled by defining JOHNSON_DEC_WRAPCNT_EN.
module johnson_phase_decoder #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8,
    localparam int PW      = $clog2(2 * WIDTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic [WIDTH-1:0]   i_jc_in,
    output logic [PW-1:0]      o_phase,
    output logic [2*WIDTH-1:0] o_onehot,
    output logic               o_valid,
    output logic               o_illegal,
    output logic               o_step_err,
    output logic               o_locked,
    output logic [CNT_W-1:0]   o_wrap_cnt
);

    localparam int N  = 2 * WIDTH;
    localparam int CW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        S_UNLOCK = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nx;
    logic [PW-1:0]     r_prev_phase;
    logic              r_prev_ok;
    logic [PW-1:0]     r_phase;
    logic [N-1:0]      r_onehot;
    logic              r_valid;
    logic              r_illegal;
    logic              r_step_err;

    int                w_pop;
    int                w_dec;
    logic [WIDTH-1:0]  w_enc;
    logic [PW-1:0]     w_phase;
    logic              w_legal;
    logic [PW-1:0]     w_next_exp;
    logic              w_match;
    logic              w_good;
    logic              w_serr;
    logic              w_ill;

    // Decode the incoming code and re-encode the phase to prove legality
    always_comb begin
        w_pop = 0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + int'(i_jc_in[i]);
        end
        if (i_jc_in == '0) begin
            w_dec = 0;
        end else if (i_jc_in[0]) begin
            w_dec = w_pop;
        end else begin
            w_dec = N - w_pop;
        end
        w_phase = PW'(w_dec);
        w_enc   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_dec <= WIDTH) begin
                w_enc[i] = (i < w_dec);
            end else begin
                w_enc[i] = (i >= w_dec - WIDTH);
            end
        end
        w_legal = (w_enc == i_jc_in);
    end

    // Classify the current sample against the previous legal phase
    always_comb begin
        w_next_exp = (r_prev_phase == PW'(N - 1)) ? '0 : r_prev_phase + 1'b1;
        w_match    = (w_phase == w_next_exp);
        w_good     = i_en & w_legal & r_prev_ok & w_match;
        w_serr     = i_en & w_legal & r_prev_ok & ~w_match;
        w_ill      = i_en & ~w_legal;
    end

    // Lock FSM next-state and good-step counter
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (w_ill | w_serr) begin
            w_state_nx = S_UNLOCK;
            w_cnt_nx   = '0;
        end else if (w_good) begin
            unique case (r_state)
                S_UNLOCK: begin
                    w_cnt_nx   = CW'(1);
                    w_state_nx = (LOCK_CNT <= 1) ? S_LOCKED : S_TRACK;
                end
                S_TRACK: begin
                    w_cnt_nx = r_cnt + 1'b1;
                    if (r_cnt >= CW'(LOCK_CNT - 1)) begin
                        w_state_nx = S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    w_state_nx = S_LOCKED;
                end
                default: begin
                    w_state_nx = S_UNLOCK;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // FSM state and counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_UNLOCK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Registered decode outputs and previous-phase tracking
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase      <= '0;
            r_onehot     <= '0;
            r_valid      <= 1'b0;
            r_illegal    <= 1'b0;
            r_step_err   <= 1'b0;
            r_prev_phase <= '0;
            r_prev_ok    <= 1'b0;
        end else begin
            r_illegal  <= w_ill;
            r_step_err <= w_serr;
            if (i_en) begin
                if (w_legal) begin
                    r_phase      <= w_phase;
                    r_onehot     <= N'(1) << w_phase;
                    r_valid      <= 1'b1;
                    r_prev_phase <= w_phase;
                    r_prev_ok    <= 1'b1;
                end else begin
                    r_onehot  <= '0;
                    r_valid   <= 1'b0;
                    r_prev_ok <= 1'b0;
                end
            end
        end
    end

`ifdef JOHNSON_DEC_WRAPCNT_EN
    logic [CNT_W-1:0] r_wrap;
    logic             w_wrap;

    // A revolution is a good step out of the last phase while already locked
    always_comb begin
        w_wrap = w_good & (r_prev_phase == PW'(N - 1)) & (r_state == S_LOCKED);
    end

    // Saturating revolution counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrap <= '0;
        end else if (w_wrap && (r_wrap != '1)) begin
            r_wrap <= r_wrap + 1'b1;
        end
    end

    assign o_wrap_cnt = r_wrap;
`else
    assign o_wrap_cnt = '0;
`endif

    assign o_phase    = r_phase;
    assign o_onehot   = r_onehot;
    assign o_valid    = r_valid;
    assign o_illegal  = r_illegal;
    assign o_step_err = r_step_err;
    assign o_locked   = (r_state == S_LOCKED);

endmodule
